// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS memory/write-back stage.
//   - Opcode constants for the loads and stores this stage handles.
//   - FSM state encoding for mem_wb_stage.
//   - Small decode helpers used by the stage and by load_align.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // accepting
    ST_MEM  = 2'd1,  // request outstanding
    ST_WB   = 2'd2   // write strobe cycle, also accepting
  } stage_state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  // Word accesses must be 4-byte aligned; byte accesses never misalign.
  function automatic logic is_word(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Little-endian byte enables: bit i covers data bits 8i+7:8i.
  function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] off);
    if (is_word(op)) return 4'b1111;
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load data formatter.
//   rdata  in  32  raw word returned by data memory
//   offset in  2   byte offset of the access (address bits 1:0)
//   opcode in  6   load opcode (LW / LB / LBU)
//   data   out 32  value to write to the register file
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [5:0]  opcode,
  output logic [31:0] data
);

  logic [7:0] sel_byte;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_byte = 8'h00;
    data     = rdata;
    unique case (offset)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    if (opcode == OP_LB)       data = {{24{sel_byte[7]}}, sel_byte};
    else if (opcode == OP_LBU) data = {24'h000000, sel_byte};
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back stage of the 32-bit MIPS pipeline.
//   in_valid/in_ready          upstream handshake (one instruction per transfer)
//   opcode, alu_result,
//   store_data, dest_addr,
//   dest_wen                   instruction fields from the ALU stage
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata         data-memory request, held stable until ack/timeout
//   mem_rdata/mem_ack          data-memory response
//   write/write_address/
//   write_material             register-file write port, one strobe per instruction
//   misalign_err               pulse: misaligned LW/SW dropped without a request
//   timeout_err                pulse: access abandoned after ACK_TIMEOUT cycles
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_addr,
  input  logic        dest_wen,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        write,
  output logic [4:0]  write_address,
  output logic [31:0] write_material,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  stage_state_e state;
  logic [7:0]   wait_cnt;
  logic [5:0]   op_q;      // opcode of the access in flight
  logic [1:0]   off_q;     // byte offset of the access in flight
  logic [4:0]   dest_q;    // load destination
  logic [31:0]  load_data;

  logic accept;
  logic in_load, in_store, in_misalign;

  assign in_ready    = (state == ST_IDLE) || (state == ST_WB);
  assign accept      = in_valid && in_ready;
  assign in_load     = is_load(opcode);
  assign in_store    = is_store(opcode);
  assign in_misalign = is_word(opcode) && (alu_result[1:0] != 2'b00);

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .opcode (op_q),
    .data   (load_data)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wait_cnt       <= 8'd0;
      op_q           <= 6'd0;
      off_q          <= 2'd0;
      dest_q         <= 5'd0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_be         <= 4'b0000;
      mem_addr       <= 32'd0;
      mem_wdata      <= 32'd0;
      write          <= 1'b0;
      write_address  <= 5'd0;
      write_material <= 32'd0;
      misalign_err   <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      // Strobes and pulses last one cycle unless re-asserted below.
      write        <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;

      if (state == ST_MEM) begin
        // Ack is checked first so an ack on the final counted cycle still completes.
        if (mem_ack) begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= 4'b0000;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          if (is_load(op_q)) begin
            write          <= (dest_q != 5'd0);
            write_address  <= dest_q;
            write_material <= load_data;
            state          <= ST_WB;
          end else begin
            state <= ST_IDLE;
          end
        end else if (wait_cnt == TMO_LAST) begin
          mem_req     <= 1'b0;
          mem_we      <= 1'b0;
          mem_be      <= 4'b0000;
          mem_addr    <= 32'd0;
          mem_wdata   <= 32'd0;
          timeout_err <= 1'b1;
          state       <= ST_IDLE;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else if (accept) begin
        if (in_misalign) begin
          // Dropped: no request, no write; the pulse marks the lost slot.
          misalign_err <= 1'b1;
          state        <= ST_IDLE;
        end else if (in_load || in_store) begin
          mem_req   <= 1'b1;
          mem_we    <= in_store;
          mem_be    <= byte_en(opcode, alu_result[1:0]);
          mem_addr  <= {alu_result[31:2], 2'b00};
          mem_wdata <= (opcode == OP_SW) ? store_data :
                       (opcode == OP_SB) ? {4{store_data[7:0]}} : 32'd0;
          op_q      <= opcode;
          off_q     <= alu_result[1:0];
          dest_q    <= dest_addr;
          wait_cnt  <= 8'd0;
          state     <= ST_MEM;
        end else begin
          write          <= dest_wen && (dest_addr != 5'd0);
          write_address  <= dest_addr;
          write_material <= alu_result;
          state          <= ST_WB;
        end
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage (ACK_TIMEOUT = 4).
// Inputs change #1 after a rising edge or on a falling edge; outputs are sampled on falling edges.
module tb_mem_wb_stage;

  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, ADDU = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  dest_addr = 5'd0;
  logic        dest_wen = 1'b0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        write;
  logic [4:0]  write_address;
  logic [31:0] write_material;
  logic        misalign_err, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_result(alu_result), .store_data(store_data),
    .dest_addr(dest_addr), .dest_wen(dest_wen),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .write(write), .write_address(write_address), .write_material(write_material),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called on a falling edge; presents one instruction, lets it transfer, returns on the next falling edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] dst, input logic wen);
    opcode = op; alu_result = res; store_data = sd; dest_addr = dst; dest_wen = wen;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called on the falling edge just after the accept edge; ack is sampled n edges after acceptance.
  task automatic ack_after(input int n, input logic [31:0] rdata);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  initial begin
    int req_cycles, terr_cnt, wr_cnt;

    // Reset values
    #3;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_we/be", {27'd0, mem_we, mem_be}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst write", {26'd0, write, write_address}, 32'd0);
    check("rst write_material", write_material, 32'd0);
    check("rst errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // ALU op: one write, one cycle later
    issue(ADDU, 32'h0000_0055, 32'd0, 5'd5, 1'b1);
    check("alu write", 32'(write), 32'd1);
    check("alu write_address", 32'(write_address), 32'd5);
    check("alu write_material", write_material, 32'h55);
    check("alu in_ready in WB", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("alu write single cycle", 32'(write), 32'd0);

    // Back-to-back ALU ops out of WB: one write per cycle
    opcode = ADDU; alu_result = 32'hAAAA_0007; dest_addr = 5'd7; dest_wen = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 alu_result = 32'hBBBB_0009; dest_addr = 5'd9;
    @(negedge clk);
    check("b2b first write", {write, 26'd0, write_address}, {1'b1, 26'd0, 5'd7});
    check("b2b first data", write_material, 32'hAAAA_0007);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b second write", {write, 26'd0, write_address}, {1'b1, 26'd0, 5'd9});
    check("b2b second data", write_material, 32'hBBBB_0009);
    @(negedge clk);

    // ALU op with dest_wen=0 writes nothing
    issue(ADDU, 32'h1111_1111, 32'd0, 5'd3, 1'b0);
    check("alu no wen", 32'(write), 32'd0);
    @(negedge clk);

    // LB at 0x102, ack after 3 cycles
    issue(LB, 32'h0000_0102, 32'd0, 5'd8, 1'b0);
    check("lb mem_req", 32'(mem_req), 32'd1);
    check("lb mem_we", 32'(mem_we), 32'd0);
    check("lb mem_be", 32'(mem_be), 32'b0100);
    check("lb mem_addr", mem_addr, 32'h100);
    check("lb in_ready busy", 32'(in_ready), 32'd0);
    check("lb no early write", 32'(write), 32'd0);
    ack_after(3, 32'h0080_0000);
    check("lb write", 32'(write), 32'd1);
    check("lb write_address", 32'(write_address), 32'd8);
    check("lb write_material", write_material, 32'hFFFF_FF80);
    check("lb mem_req dropped", 32'(mem_req), 32'd0);
    @(negedge clk);

    // Same access as LBU
    issue(LBU, 32'h0000_0102, 32'd0, 5'd8, 1'b0);
    ack_after(3, 32'h0080_0000);
    check("lbu write_material", write_material, 32'h0000_0080);
    check("lbu write", 32'(write), 32'd1);
    @(negedge clk);

    // SB at 0x3
    issue(SB, 32'h0000_0003, 32'h1234_56AB, 5'd4, 1'b0);
    check("sb mem_we", 32'(mem_we), 32'd1);
    check("sb mem_be", 32'(mem_be), 32'b1000);
    check("sb mem_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb mem_addr", mem_addr, 32'h0);
    ack_after(1, 32'd0);
    check("sb no write", 32'(write), 32'd0);
    check("sb ready", {31'd0, in_ready}, 32'd1);
    check("sb mem_req dropped", 32'(mem_req), 32'd0);

    // SW aligned: full lanes
    issue(SW, 32'h0000_0040, 32'hCAFE_F00D, 5'd4, 1'b0);
    check("sw be/we", {27'd0, mem_we, mem_be}, {27'd0, 1'b1, 4'b1111});
    check("sw mem_wdata", mem_wdata, 32'hCAFE_F00D);
    ack_after(2, 32'd0);
    check("sw no write", 32'(write), 32'd0);

    // Misaligned LW at 0x6
    issue(LW, 32'h0000_0006, 32'd0, 5'd2, 1'b0);
    check("misalign no req", 32'(mem_req), 32'd0);
    check("misalign pulse", 32'(misalign_err), 32'd1);
    check("misalign no write", 32'(write), 32'd0);
    @(negedge clk);
    check("misalign pulse once", 32'(misalign_err), 32'd0);
    check("misalign still no req", 32'(mem_req), 32'd0);

    // LW timeout with no ack
    issue(LW, 32'h0000_0008, 32'd0, 5'd6, 1'b0);
    req_cycles = 0; terr_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) req_cycles++;
      if (timeout_err) terr_cnt++;
      if (write) wr_cnt++;
      @(negedge clk);
    end
    check("timeout mem_req cycles", 32'(req_cycles), 32'd4);
    check("timeout pulse count", 32'(terr_cnt), 32'd1);
    check("timeout no write", 32'(wr_cnt), 32'd0);
    check("timeout in_ready", 32'(in_ready), 32'd1);

    // Ack on the last counted cycle beats timeout
    issue(LW, 32'h0000_000C, 32'd0, 5'd10, 1'b0);
    ack_after(4, 32'h8765_4321);
    check("ack wins write", 32'(write), 32'd1);
    check("ack wins data", write_material, 32'h8765_4321);
    check("ack wins no timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);

    // Minimum latency LW with immediate ack
    issue(LW, 32'h0000_0010, 32'd0, 5'd11, 1'b0);
    ack_after(1, 32'h0102_0304);
    check("lw fast write", {write, 26'd0, write_address}, {1'b1, 26'd0, 5'd11});
    check("lw fast data", write_material, 32'h0102_0304);
    @(negedge clk);

    // Load to r0 never writes
    issue(LW, 32'h0000_0014, 32'd0, 5'd0, 1'b1);
    ack_after(1, 32'hFFFF_FFFF);
    check("r0 no write", 32'(write), 32'd0);
    @(negedge clk);

    // Stray ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk); mem_ack = 1'b0;
    check("idle ack ignored", {30'd0, write, mem_req}, 32'd0);

    // Reset during MEM
    issue(LW, 32'h0000_0020, 32'd0, 5'd12, 1'b0);
    check("pre-reset mem_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset mem_req", 32'(mem_req), 32'd0);
    check("async reset mem_be/addr", {mem_be, mem_addr[27:0]}, 32'd0);
    check("async reset in_ready", 32'(in_ready), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("post-reset ack ignored", {29'd0, write, mem_req, timeout_err}, 32'd0);
    @(negedge clk);
    check("post-reset quiet", {29'd0, write, misalign_err, timeout_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back stage of the 32-bit MIPS pipeline, directly downstream of the ALU stage. It accepts one ALU result per handshake and performs the load/store on a req/ack data-memory port, waiting as long as the memory needs. It drives the register-file write port (`write`, `write_address`, `write_material`), and deasserts `in_ready` while busy so the upstream stages stall.

## Interface
- `ACK_TIMEOUT`, 16: cycles `mem_req` may wait for `mem_ack` before the access is abandoned; legal range 2..255.
- `clk`  in  1  single pipeline clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU stage presents an instruction.
- `in_ready`  out  1  stage can accept; a transfer happens when `in_valid && in_ready` at a rising edge.
- `opcode`  in  6  instruction opcode.
- `alu_result`  in  32  effective address for loads/stores; result value otherwise.
- `store_data`  in  32  Rt value for stores.
- `dest_addr`  in  5  destination register.
- `dest_wen`  in  1  non-memory instruction writes `dest_addr`.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  1 = store.
- `mem_be`  out  4  byte enables; bit i covers bits 8i+7:8i.
- `mem_addr`  out  32  word address; `alu_result` with [1:0] forced to 0.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  load data, valid only in the `mem_ack` cycle.
- `mem_ack`  in  1  access complete.
- `write`  out  1  register-file write strobe, one cycle per instruction.
- `write_address`  out  5  register-file write address.
- `write_material`  out  32  register-file write data.
- `misalign_err`  out  1  one-cycle pulse: misaligned word access dropped.
- `timeout_err`  out  1  one-cycle pulse: access abandoned after `ACK_TIMEOUT`.

## Operation
- Opcodes:
  - LW 6'b100011, LB 6'b100000, LBU 6'b100100 (loads).
  - SW 6'b101011, SB 6'b101000 (stores).
  - Every other opcode is a non-memory op.
- FSM states:
  - IDLE: accepting.
  - MEM: request outstanding.
  - WB: write strobe cycle, also accepting.
- `in_ready` = state is IDLE or WB.
- Non-memory op accepted:
  - Latch `alu_result`/`dest_addr` and go to WB.
  - In WB, `write` = `dest_wen && dest_addr != 0`.
- Load or store accepted: go to MEM and drive `mem_req`=1.
  - `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are held constant until ack or timeout.
- Store lanes:
  - SW: be 4'b1111, wdata = `store_data`.
  - SB: be = 1<<addr[1:0], wdata = `store_data[7:0]` replicated into all four lanes.
- Load lanes (little-endian):
  - LW: be 4'b1111.
  - LB/LBU: be = 1<<addr[1:0]; select byte addr[1:0] of `mem_rdata`. LB sign-extends it, LBU zero-extends it.
- On `mem_ack` in MEM:
  - Load: register the aligned data and go to WB. `write`=1 unless `dest_addr`==0. `dest_wen` is ignored for loads.
  - Store: go to IDLE; no write.
- Timeout:
  - A cycle counter runs from 0 in MEM.
  - If no ack arrives by count `ACK_TIMEOUT`-1: drop `mem_req`, pulse `timeout_err`, go to IDLE, no write.
- Misaligned LW/SW (addr[1:0] != 0):
  - No request is issued; `misalign_err` pulses the next cycle.
  - State goes to IDLE for one cycle (one bubble); no write.
- `mem_ack` outside MEM is ignored.
- Register 0 is never written.

## Timing
- Reset values: state IDLE, `in_ready` 1, and 0 on `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `write`, `write_address`, `write_material`, `misalign_err`, `timeout_err`.
- Non-memory op accepted at edge N: `write` is high for cycle N..N+1 (one cycle). Back-to-back ops give one write per cycle.
- Memory op accepted at edge N:
  - `mem_req` is high from edge N.
  - Ack sampled at edge M: load `write` is high for one cycle after edge M; `mem_req` is low after edge M.
  - Minimum load latency: ack in the first MEM cycle gives write one cycle after the request is sampled.
- A new instruction accepted in WB proceeds in the same edge the write retires; there is no bubble.
- Ack and timeout in the same cycle: ack wins.
- Reset asserted mid-access:
  - All outputs clear immediately (asynchronous).
  - The in-flight access is abandoned; no write and no error pulse.

## Structure
- Package `mips_pkg`:
  - Opcode localparams (OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB).
  - FSM state enum.
- Sub-module `load_align`: combinational; (`mem_rdata`, addr[1:0], opcode) → 32-bit write data.
- The FSM, timeout counter and output registers live in `mem_wb_stage`.

## Test plan
- ALU op, `alu_result`=32'h0000_0055, `dest_addr`=5, `dest_wen`=1 → `write`=1 one cycle later, `write_address`=5, `write_material`=32'h55.
- LB at address 32'h0000_0102, `mem_rdata`=32'h00_80_00_00, ack after 3 cycles → `mem_be`=4'b0100, `mem_addr`=32'h100, `write_material`=32'hFFFF_FF80. The same access as LBU → 32'h0000_0080.
- SB at address 32'h3, `store_data`=32'h1234_56AB → `mem_we`=1, `mem_be`=4'b1000, `mem_wdata`=32'hABAB_ABAB; no `write`.
- LW at address 32'h6 → no `mem_req`, `misalign_err` pulses once, no `write`.
- LW with `ACK_TIMEOUT`=4 and no ack → `mem_req` high for exactly 4 cycles, `timeout_err` pulse, `in_ready` back to 1.
- Load to `dest_addr`=0 → `write` stays 0. Reset asserted during MEM → `mem_req` drops immediately; a later `mem_ack` is ignored.
